// File: rtl/rom_microseq_pkg.sv
// rom_microseq_pkg: shared widths, IR field positions and sequencer states.
package rom_microseq_pkg;
    localparam int ADDR_W     = 6;
    localparam int IR_W       = 26;
    localparam int RA_MSB     = 25;
    localparam int RB_MSB     = 21;
    localparam int RD_MSB     = 17;
    localparam int WE_BIT     = 13;
    localparam int IMMSEL_BIT = 12;
    localparam int ALUOP_MSB  = 10;
    localparam int IMM_MSB    = 7;
    typedef enum logic [2:0] {IDLE, FETCH, EXEC, PAUSE, DONE} state_e;
endpackage

// File: rtl/rom_microseq_if.sv
// rom_microseq_if: control, ROM and decoded-field signals of the sequencer.
interface rom_microseq_if;
    import rom_microseq_pkg::*;
    logic              start;
    logic              abort;
    logic              step_mode;
    logic              step;
    logic [IR_W-1:0]   rom_data;
    logic [ADDR_W-1:0] rom_addr;
    logic [3:0]        ra_addr;
    logic [3:0]        rb_addr;
    logic [3:0]        rd_addr;
    logic              rf_we;
    logic              imm_sel;
    logic [2:0]        alu_op;
    logic [7:0]        imm;
    logic              busy;
    logic              done;
    modport master (
        output start, abort, step_mode, step, rom_data,
        input  rom_addr, ra_addr, rb_addr, rd_addr, rf_we, imm_sel, alu_op, imm, busy, done
    );
    modport slave (
        input  start, abort, step_mode, step, rom_data,
        output rom_addr, ra_addr, rb_addr, rd_addr, rf_we, imm_sel, alu_op, imm, busy, done
    );
endinterface

// File: rtl/rom_microseq_decode.sv
// microinst_decode: combinational split of the instruction register into fields.
module microinst_decode
    import rom_microseq_pkg::*;
(
    input  logic [IR_W-1:0] ir,
    output logic [3:0]      ra_addr,
    output logic [3:0]      rb_addr,
    output logic [3:0]      rd_addr,
    output logic            we_bit,
    output logic            imm_sel,
    output logic [2:0]      alu_op,
    output logic [7:0]      imm
);
    // IR[11] is reserved: carried in the IR but never decoded
    logic unused_rsvd;
    assign unused_rsvd = ir[11];
    assign ra_addr = ir[RA_MSB -: 4];
    assign rb_addr = ir[RB_MSB -: 4];
    assign rd_addr = ir[RD_MSB -: 4];
    assign we_bit  = ir[WE_BIT];
    assign imm_sel = ir[IMMSEL_BIT];
    assign alu_op  = ir[ALUOP_MSB -: 3];
    assign imm     = ir[IMM_MSB -: 8];
endmodule

// File: rtl/rom_microseq.sv
// rom_microseq: PC/IR sequencer over a 64-entry instruction ROM with step and abort control.
module rom_microseq
    import rom_microseq_pkg::*;
#(
    parameter logic [ADDR_W-1:0] LAST_ADDR = 6'd5
) (
    input logic           clk,
    input logic           rst,
    rom_microseq_if.slave bus
);
    localparam logic [2:0] S_IDLE  = IDLE;
    localparam logic [2:0] S_FETCH = FETCH;
    localparam logic [2:0] S_EXEC  = EXEC;
    localparam logic [2:0] S_PAUSE = PAUSE;
    localparam logic [2:0] S_DONE  = DONE;
    logic [2:0]        state;
    logic [ADDR_W-1:0] pc;
    logic [IR_W-1:0]   ir;
    logic              we_bit;
    logic              last;
    logic              wrap;
    assign last = pc == LAST_ADDR;
    assign wrap = &pc;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            pc    <= '0;
            ir    <= '0;
        end else if (bus.abort) begin
            state <= S_IDLE;
            pc    <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: if (bus.start) begin
                    state <= S_FETCH;
                    pc    <= '0;
                end
                S_FETCH: begin
                    ir    <= bus.rom_data;
                    state <= S_EXEC;
                end
                // running off the top of the ROM ends the program instead of wrapping
                S_EXEC: if (last) state <= S_DONE;
                    else if (bus.step_mode) state <= S_PAUSE;
                    else if (wrap) state <= S_DONE;
                    else begin
                        state <= S_FETCH;
                        pc    <= pc + 6'd1;
                    end
                S_PAUSE: if (bus.step) begin
                    state <= wrap ? S_DONE : S_FETCH;
                    pc    <= wrap ? pc : pc + 6'd1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
    microinst_decode u_decode (
        .ir      (ir),
        .ra_addr (bus.ra_addr),
        .rb_addr (bus.rb_addr),
        .rd_addr (bus.rd_addr),
        .we_bit  (we_bit),
        .imm_sel (bus.imm_sel),
        .alu_op  (bus.alu_op),
        .imm     (bus.imm)
    );
    // abort suppresses the write of the EXEC cycle it lands in
    assign bus.rf_we    = (state == S_EXEC) && we_bit && !bus.abort;
    assign bus.rom_addr = pc;
    assign bus.busy     = (state == S_FETCH) || (state == S_EXEC) || (state == S_PAUSE);
    assign bus.done     = state == S_DONE;
endmodule

// File: tb/tb_rom_microseq.sv
// tb_rom_microseq: directed tests of the ROM sequencer with lab program and a full-ROM run.
module tb_rom_microseq;
    logic clk;
    logic rst;
    int   errors;
    int   checks;
    logic [25:0] rom_a [64];
    logic [25:0] rom_b [64];

    rom_microseq_if ifa ();
    rom_microseq_if ifb ();

    rom_microseq #(.LAST_ADDR(6'd5)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
    rom_microseq #(.LAST_ADDR(6'd63)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

    assign ifa.rom_data = rom_a[ifa.rom_addr];
    assign ifb.rom_data = rom_b[ifb.rom_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [25:0] mk(input logic [3:0] ra, rb, rd, input logic we, isel,
                                       input logic [2:0] op, input logic [7:0] im);
        return {ra, rb, rd, we, isel, 1'b0, op, im};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if ({ifa.rom_addr, ifa.ra_addr, ifa.rb_addr, ifa.rd_addr, ifa.rf_we, ifa.imm_sel,
             ifa.alu_op, ifa.imm, ifa.busy, ifa.done} !== 38'd0) begin
            errors++;
            $display("FAIL reset_a: got addr=%0d imm=%0h busy=%b done=%b we=%b, want all 0",
                     ifa.rom_addr, ifa.imm, ifa.busy, ifa.done, ifa.rf_we);
        end
        checks++;
        if ({ifb.rom_addr, ifb.busy, ifb.done, ifb.rf_we} !== 9'd0) begin
            errors++;
            $display("FAIL reset_b: got addr=%0d busy=%b done=%b we=%b, want 0",
                     ifb.rom_addr, ifb.busy, ifb.done, ifb.rf_we);
        end
    endtask

    task automatic test_free_run();
        int we_cnt;
        logic exp_we;
        we_cnt = 0;
        ifa.start = 1'b1;
        tick();
        ifa.start = 1'b0;
        for (int c = 1; c <= 14; c++) begin
            if (ifa.rf_we) we_cnt++;
            exp_we = (c % 2 == 0) && (c <= 12);
            checks++;
            if (ifa.rf_we !== exp_we) begin
                errors++;
                $display("FAIL free_we c=%0d: got %b want %b", c, ifa.rf_we, exp_we);
            end
            if (c == 2) begin
                checks++;
                if ({ifa.rd_addr, ifa.imm_sel, ifa.imm} !== {4'd0, 1'b1, 8'h7D}) begin
                    errors++;
                    $display("FAIL free_c2: got rd=%0d isel=%b imm=%h want rd=0 isel=1 imm=7d",
                             ifa.rd_addr, ifa.imm_sel, ifa.imm);
                end
            end
            if (c == 8) begin
                checks++;
                if ({ifa.ra_addr, ifa.rb_addr, ifa.rd_addr, ifa.imm_sel, ifa.alu_op} !==
                    {4'd0, 4'd1, 4'd10, 1'b0, 3'd6}) begin
                    errors++;
                    $display("FAIL free_c8: got ra=%0d rb=%0d rd=%0d isel=%b op=%0d want 0 1 10 0 6",
                             ifa.ra_addr, ifa.rb_addr, ifa.rd_addr, ifa.imm_sel, ifa.alu_op);
                end
            end
            if (c == 12) begin
                checks++;
                if ({ifa.ra_addr, ifa.rb_addr, ifa.rd_addr, ifa.alu_op, ifa.rom_addr} !==
                    {4'd10, 4'd11, 4'd12, 3'd0, 6'd5}) begin
                    errors++;
                    $display("FAIL free_c12: got ra=%0d rb=%0d rd=%0d op=%0d addr=%0d want 10 11 12 0 5",
                             ifa.ra_addr, ifa.rb_addr, ifa.rd_addr, ifa.alu_op, ifa.rom_addr);
                end
            end
            if (c >= 13) begin
                checks++;
                if ({ifa.done, ifa.busy} !== 2'b10) begin
                    errors++;
                    $display("FAIL free_done c=%0d: got done=%b busy=%b want 1 0", c, ifa.done, ifa.busy);
                end
            end
            tick();
        end
        checks++;
        if (we_cnt != 6) begin
            errors++;
            $display("FAIL free_we_count: got %0d want 6", we_cnt);
        end
    endtask

    task automatic test_step_mode();
        ifa.step_mode = 1'b1;
        ifa.start = 1'b1;
        tick();
        ifa.start = 1'b0;
        tick();
        checks++;
        if ({ifa.rf_we, ifa.rom_addr} !== {1'b1, 6'd0}) begin
            errors++;
            $display("FAIL step_exec0: got we=%b addr=%0d want 1 0", ifa.rf_we, ifa.rom_addr);
        end
        tick();
        for (int i = 0; i < 10; i++) begin
            checks++;
            if ({ifa.busy, ifa.rf_we, ifa.rom_addr, ifa.imm} !== {1'b1, 1'b0, 6'd0, 8'h7D}) begin
                errors++;
                $display("FAIL step_pause i=%0d: got busy=%b we=%b addr=%0d imm=%h want 1 0 0 7d",
                         i, ifa.busy, ifa.rf_we, ifa.rom_addr, ifa.imm);
            end
            tick();
        end
        ifa.step = 1'b1;
        tick();
        ifa.step = 1'b0;
        checks++;
        if ({ifa.rom_addr, ifa.rf_we} !== {6'd1, 1'b0}) begin
            errors++;
            $display("FAIL step_fetch1: got addr=%0d we=%b want 1 0", ifa.rom_addr, ifa.rf_we);
        end
        tick();
        checks++;
        if ({ifa.rf_we, ifa.imm} !== {1'b1, 8'h1E}) begin
            errors++;
            $display("FAIL step_exec1: got we=%b imm=%h want 1 1e", ifa.rf_we, ifa.imm);
        end
        tick();
    endtask

    task automatic test_abort();
        ifa.step = 1'b1;
        tick();
        ifa.step = 1'b0;
        tick();
        tick();
        checks++;
        if ({ifa.rom_addr, ifa.busy, ifa.rf_we} !== {6'd2, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL abort_pre: got addr=%0d busy=%b we=%b want 2 1 0", ifa.rom_addr, ifa.busy, ifa.rf_we);
        end
        ifa.abort = 1'b1;
        ifa.step = 1'b1;
        tick();
        ifa.abort = 1'b0;
        ifa.step = 1'b0;
        checks++;
        if ({ifa.busy, ifa.done, ifa.rf_we, ifa.rom_addr, ifa.imm} !== {3'b000, 6'd0, 8'h05}) begin
            errors++;
            $display("FAIL abort_idle: got busy=%b done=%b we=%b addr=%0d imm=%h want 0 0 0 0 05",
                     ifa.busy, ifa.done, ifa.rf_we, ifa.rom_addr, ifa.imm);
        end
        tick();
        tick();
        tick();
        checks++;
        if ({ifa.busy, ifa.done} !== 2'b00) begin
            errors++;
            $display("FAIL abort_stay: got busy=%b done=%b want 0 0", ifa.busy, ifa.done);
        end
        ifa.step_mode = 1'b0;
        ifa.start = 1'b1;
        tick();
        ifa.start = 1'b0;
        checks++;
        if ({ifa.rom_addr, ifa.busy} !== {6'd0, 1'b1}) begin
            errors++;
            $display("FAIL abort_restart: got addr=%0d busy=%b want 0 1", ifa.rom_addr, ifa.busy);
        end
        tick();
        checks++;
        if ({ifa.rf_we, ifa.imm} !== {1'b1, 8'h7D}) begin
            errors++;
            $display("FAIL abort_rerun: got we=%b imm=%h want 1 7d", ifa.rf_we, ifa.imm);
        end
        ifa.abort = 1'b1;
        #1;
        checks++;
        if (ifa.rf_we !== 1'b0) begin
            errors++;
            $display("FAIL abort_exec_we: got %b want 0", ifa.rf_we);
        end
        tick();
        ifa.abort = 1'b0;
        checks++;
        if ({ifa.busy, ifa.rom_addr} !== {1'b0, 6'd0}) begin
            errors++;
            $display("FAIL abort_exec_idle: got busy=%b addr=%0d want 0 0", ifa.busy, ifa.rom_addr);
        end
    endtask

    task automatic test_start_abort();
        int n;
        ifa.start = 1'b1;
        ifa.abort = 1'b1;
        tick();
        ifa.start = 1'b0;
        ifa.abort = 1'b0;
        checks++;
        if ({ifa.busy, ifa.done} !== 2'b00) begin
            errors++;
            $display("FAIL start_abort: got busy=%b done=%b want 0 0", ifa.busy, ifa.done);
        end
        ifa.start = 1'b1;
        tick();
        tick();
        tick();
        ifa.start = 1'b0;
        checks++;
        if ({ifa.rom_addr, ifa.busy, ifa.rf_we} !== {6'd1, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL start_ignored: got addr=%0d busy=%b we=%b want 1 1 0", ifa.rom_addr, ifa.busy, ifa.rf_we);
        end
        tick();
        checks++;
        if ({ifa.rom_addr, ifa.rf_we, ifa.imm} !== {6'd1, 1'b1, 8'h1E}) begin
            errors++;
            $display("FAIL start_ignored_exec: got addr=%0d we=%b imm=%h want 1 1 1e", ifa.rom_addr, ifa.rf_we, ifa.imm);
        end
        n = 0;
        while (!ifa.done && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (ifa.done !== 1'b1) begin
            errors++;
            $display("FAIL start_ignored_done: timeout, done=%b want 1", ifa.done);
        end
    endtask

    task automatic test_async_rst();
        ifa.start = 1'b1;
        tick();
        ifa.start = 1'b0;
        tick();
        checks++;
        if (ifa.rf_we !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre_exec: got we=%b want 1", ifa.rf_we);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({ifa.rom_addr, ifa.ra_addr, ifa.rb_addr, ifa.rd_addr, ifa.rf_we, ifa.imm_sel,
             ifa.alu_op, ifa.imm, ifa.busy, ifa.done} !== 38'd0) begin
            errors++;
            $display("FAIL rst_async: got addr=%0d we=%b imm=%h busy=%b done=%b want all 0",
                     ifa.rom_addr, ifa.rf_we, ifa.imm, ifa.busy, ifa.done);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
        checks++;
        if ({ifa.busy, ifa.rf_we, ifa.done} !== 3'b000) begin
            errors++;
            $display("FAIL rst_after: got busy=%b we=%b done=%b want 0 0 0", ifa.busy, ifa.rf_we, ifa.done);
        end
    endtask

    task automatic test_wrap();
        int c;
        int busy_cnt;
        int we_seen;
        busy_cnt = 0;
        we_seen = 0;
        ifb.start = 1'b1;
        tick();
        ifb.start = 1'b0;
        c = 1;
        while (!ifb.done && c < 200) begin
            if (ifb.busy) busy_cnt++;
            if (ifb.rf_we) we_seen++;
            if (c == 128) begin
                checks++;
                if ({ifb.rom_addr, ifb.imm, ifb.busy} !== {6'd63, 8'd63, 1'b1}) begin
                    errors++;
                    $display("FAIL wrap_last_exec: got addr=%0d imm=%0d busy=%b want 63 63 1",
                             ifb.rom_addr, ifb.imm, ifb.busy);
                end
            end
            tick();
            c++;
        end
        checks++;
        if (c != 129 || busy_cnt != 128) begin
            errors++;
            $display("FAIL wrap_len: got done at cycle %0d busy=%0d want 129 128", c, busy_cnt);
        end
        checks++;
        if (we_seen != 0) begin
            errors++;
            $display("FAIL wrap_we: got %0d pulses want 0", we_seen);
        end
        repeat (5) tick();
        checks++;
        if ({ifb.done, ifb.busy, ifb.rom_addr} !== {2'b10, 6'd63}) begin
            errors++;
            $display("FAIL wrap_hold: got done=%b busy=%b addr=%0d want 1 0 63", ifb.done, ifb.busy, ifb.rom_addr);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        for (int i = 0; i < 64; i++) begin
            rom_a[i] = 26'd0;
            rom_b[i] = mk(4'(i % 16), 4'd0, 4'd0, 1'b0, 1'b0, 3'd0, 8'(i));
        end
        rom_a[0] = mk(4'd0, 4'd0, 4'd0, 1'b1, 1'b1, 3'd0, 8'h7D);
        rom_a[1] = mk(4'd0, 4'd0, 4'd1, 1'b1, 1'b1, 3'd0, 8'h1E);
        rom_a[2] = mk(4'd0, 4'd0, 4'd2, 1'b1, 1'b1, 3'd0, 8'h05);
        rom_a[3] = mk(4'd0, 4'd1, 4'd10, 1'b1, 1'b0, 3'd6, 8'h00);
        rom_a[4] = mk(4'd0, 4'd2, 4'd11, 1'b1, 1'b0, 3'd1, 8'h00);
        rom_a[5] = mk(4'd10, 4'd11, 4'd12, 1'b1, 1'b0, 3'd0, 8'h00);
        {ifa.start, ifa.abort, ifa.step_mode, ifa.step} = 4'b0;
        {ifb.start, ifb.abort, ifb.step_mode, ifb.step} = 4'b0;
        test_reset();
        test_free_run();
        test_step_mode();
        test_abort();
        test_start_abort();
        test_async_rst();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/rom_microseq.md
Name: rom_microseq

Overview:
- Sequencer for the 64 x 26-bit instruction ROM that feeds the register-file/ALU datapath.
- Steps a program counter over the ROM and latches each word into an instruction register (IR).
- Decodes the IR into register-file addresses, write enable, immediate select, ALU opcode and immediate.
- Supports free-run and single-step modes, programmable last address, abort, and a done flag.

Parameters:
- LAST_ADDR, 6'd5: address of the final instruction; the program completes after its execution.
- ADDR_W, 6: ROM address width; fixed by the 64-entry ROM.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin the program at address 0; sampled in IDLE or DONE only.
- abort  in  1  synchronous cancel from any state.
- step_mode  in  1  1 = pause after every instruction.
- step  in  1  one-cycle pulse; advances past a pause.
- rom_data  in  26  ROM output for rom_addr (combinational read).
- rom_addr  out  6  current PC.
- ra_addr  out  4  IR[25:22], source A register.
- rb_addr  out  4  IR[21:18], source B register.
- rd_addr  out  4  IR[17:14], destination register.
- rf_we  out  1  IR[13] gated by EXEC state.
- imm_sel  out  1  IR[12]; 1 selects the immediate as operand B.
- alu_op  out  3  IR[10:8].
- imm  out  8  IR[7:0].
- busy  out  1  high in FETCH, EXEC and PAUSE.
- done  out  1  high in DONE.

Behaviour:
- Reset: state=IDLE, PC=0, IR=0. All outputs are 0; rom_addr=0.
- IR[11] is reserved: latched but not decoded.
- States and transitions:
  - IDLE: start=1 -> FETCH with PC=0.
  - FETCH: IR <= rom_data; -> EXEC.
  - EXEC: rf_we=IR[13] for exactly this cycle.
    - PC==LAST_ADDR -> DONE.
    - Else step_mode=1 -> PAUSE with PC held.
    - Else -> FETCH with PC<=PC+1.
  - PAUSE: step=1 -> FETCH with PC<=PC+1; otherwise hold.
  - DONE: done=1, held. start=1 -> FETCH with PC=0.
- Timing: 2 cycles per instruction in free-run. The first rf_we occurs 2 cycles after start is sampled.
- Decoded fields are driven from the IR continuously. Only rf_we is state-gated, so fields stay stable through PAUSE and DONE.
- PC increments modulo 64. If PC wraps 63->0 without hitting LAST_ADDR, go to DONE (no wrap execution).
- Ignored inputs:
  - start in FETCH, EXEC or PAUSE.
  - step outside PAUSE.
  - step_mode changes take effect at the next EXEC decision.
- abort=1 in any state -> IDLE next cycle, PC=0, IR kept; rf_we=0 during that cycle's EXEC.
  - abort beats start and step when asserted together.
- rst mid-program -> immediate IDLE with all outputs 0. No partial write is asserted after rst falls.

Decomposition:
- Package rom_microseq_pkg:
  - state enum: IDLE, FETCH, EXEC, PAUSE, DONE.
  - field constants: RA_MSB=25, RB_MSB=21, RD_MSB=17, WE_BIT=13, IMMSEL_BIT=12, ALUOP_MSB=10, IMM_MSB=7.
  - IR width 26.
- Sub-module microinst_decode: purely combinational IR-to-field split. The FSM and PC stay in the top module.

Test Plan:
- Free-run, LAST_ADDR=5 with the lab program; start pulse at cycle 0.
  - EXEC at cycles 2,4,6,8,10,12; done=1 from cycle 13.
  - Exactly 6 rf_we pulses.
  - Cycle 2: rd=0, imm_sel=1, imm=0x7D.
  - Cycle 8: ra=0, rb=1, rd=10, imm_sel=0, alu_op=6.
  - Cycle 12: ra=10, rb=11, rd=12, alu_op=0.
- Step mode: step_mode=1, start.
  - After the first EXEC, state PAUSE with rom_addr=0 and fields held, for 10 idle cycles.
  - step pulse -> rom_addr=1 next cycle, then EXEC with imm=0x1E.
- Abort during PAUSE at PC=2 -> IDLE next cycle, rom_addr=0, no rf_we.
  - A later start re-runs from address 0.
- Simultaneous start+abort in IDLE -> remains IDLE.
  - start in EXEC is ignored: PC sequence is unchanged.
- Async rst asserted mid-EXEC between clock edges -> rf_we drops to 0 without a clock edge; all outputs 0.
- LAST_ADDR=63 with all words having IR[13]=0 -> 64 EXECs, no rf_we, PC reaches 63 then DONE (no wrap).
